// File: rtl/keypad_pkg.sv
// Shared types and the 4x4 hex keypad map for the keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONFIRM,
        ST_PRESSED
    } dbnc_state_t;

    typedef enum logic [1:0] {
        RES_NONE,
        RES_SINGLE,
        RES_MULTI
    } scan_res_t;

    // Indexed [column][row]; column 0 is the leftmost keypad column.
    localparam logic [3:0] KEY_MAP [4][4] = '{
        '{4'h1, 4'h4, 4'h7, 4'h0},
        '{4'h2, 4'h5, 4'h8, 4'hF},
        '{4'h3, 4'h6, 4'h9, 4'hE},
        '{4'hA, 4'hB, 4'hC, 4'hD}
    };

endpackage

// File: rtl/keypad_scan_decode_if.sv
// Decoded-key bus: hex code, one-cycle accept strobe, held level.
// Producer owns all signals; there is no backpressure path.
interface keypad_scan_decode_if;
    logic [3:0] KEY;
    logic       KEY_VALID;
    logic       KEY_HELD;

    modport master (output KEY, output KEY_VALID, output KEY_HELD);
    modport slave  (input  KEY, input  KEY_VALID, input  KEY_HELD);
endinterface

// File: rtl/keypad_col_scan.sv
// Column scanner: row synchronizer, column drive, capture and per-scan classification.
// Latency: scan_end pulses 1 cycle after the column-3 capture edge; period 4*SCAN_DIV.
// Backpressure: none; results are valid only while scan_end is high.
module keypad_col_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       scan_end,
    output scan_res_t  res_kind,
    output logic [3:0] res_code
);

    localparam int CW = $clog2(SCAN_DIV);

    logic [CW-1:0] dwell;
    logic [1:0]    col_idx;
    logic [3:0]    row_meta;
    logic [3:0]    row_sync;
    logic [15:0]   down;
    logic [4:0]    hits;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dwell    <= '0;
            col_idx  <= '0;
            row_meta <= 4'hF;
            row_sync <= 4'hF;
            down     <= '0;
            scan_end <= 1'b0;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
            scan_end <= 1'b0;
            if (dwell == CW'(SCAN_DIV - 1)) begin
                dwell   <= '0;
                col_idx <= col_idx + 2'd1;
                // Rows are active-low; store as active-high "key down" bits.
                down[{col_idx, 2'b00} +: 4] <= ~row_sync;
                scan_end <= (col_idx == 2'd3);
            end else begin
                dwell <= dwell + CW'(1);
            end
        end
    end

    assign col = ~(4'b0001 << col_idx);

    always_comb begin
        hits     = '0;
        res_code = '0;
        res_kind = RES_NONE;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (down[c*4 + r]) begin
                    hits     = hits + 5'd1;
                    res_code = KEY_MAP[c][r];
                end
            end
        end
        if (hits == 5'd1) begin
            res_kind = RES_SINGLE;
        end else if (hits > 5'd1) begin
            res_kind = RES_MULTI;
        end
    end

endmodule

// File: rtl/keypad_scan_decode.sv
// 4x4 hex keypad scanner with scan-level debounce; optional auto-repeat under KEYPAD_REPEAT_EN.
// Latency: KEY_VALID 1 cycle after the scan end completing DEBOUNCE_SCANS matching scans.
// Backpressure: none; KEY_VALID is a fire-and-forget one-cycle strobe.
module keypad_scan_decode
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 250
) (
    input  logic                        CLK100MHZ,
    input  logic                        CPU_RESETN,
    input  logic [3:0]                  ROW,
    output logic [3:0]                  COL,
    keypad_scan_decode_if.master        key_bus
);

    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);

    if (SCAN_DIV < 4)       begin : g_chk_div $error("SCAN_DIV must be at least 4"); end
    if (DEBOUNCE_SCANS < 1) begin : g_chk_dbn $error("DEBOUNCE_SCANS must be at least 1"); end
    if (REPEAT_SCANS < 1)   begin : g_chk_rpt $error("REPEAT_SCANS must be at least 1"); end

    logic        scan_end;
    scan_res_t   res_kind;
    logic [3:0]  res_code;

    dbnc_state_t state, state_n;
    logic [3:0]  cand, cand_n;
    logic [3:0]  key_q, key_n;
    logic        valid_q, valid_n;
    logic [DW-1:0] match_cnt, match_n;
    logic [DW-1:0] rel_cnt, rel_n;

    keypad_col_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
        .clk      (CLK100MHZ),
        .rst_n    (CPU_RESETN),
        .row      (ROW),
        .col      (COL),
        .scan_end (scan_end),
        .res_kind (res_kind),
        .res_code (res_code)
    );

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_SCANS + 1);
    logic [RW-1:0] rpt_cnt, rpt_n;

    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) rpt_cnt <= '0;
        else             rpt_cnt <= rpt_n;
    end
`endif

    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            state     <= ST_IDLE;
            cand      <= '0;
            key_q     <= '0;
            valid_q   <= 1'b0;
            match_cnt <= '0;
            rel_cnt   <= '0;
        end else begin
            state     <= state_n;
            cand      <= cand_n;
            key_q     <= key_n;
            valid_q   <= valid_n;
            match_cnt <= match_n;
            rel_cnt   <= rel_n;
        end
    end

    always_comb begin
        state_n = state;
        cand_n  = cand;
        key_n   = key_q;
        valid_n = 1'b0;
        match_n = match_cnt;
        rel_n   = rel_cnt;
`ifdef KEYPAD_REPEAT_EN
        rpt_n   = rpt_cnt;
`endif
        if (scan_end) begin
            case (state)
                ST_IDLE: begin
                    if (res_kind == RES_SINGLE) begin
                        cand_n  = res_code;
                        match_n = DW'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            state_n = ST_PRESSED;
                            key_n   = res_code;
                            valid_n = 1'b1;
                            rel_n   = '0;
`ifdef KEYPAD_REPEAT_EN
                            rpt_n   = '0;
`endif
                        end else begin
                            state_n = ST_CONFIRM;
                        end
                    end
                end
                ST_CONFIRM: begin
                    if (res_kind == RES_SINGLE && res_code == cand) begin
                        match_n = match_cnt + DW'(1);
                        if (match_n == DW'(DEBOUNCE_SCANS)) begin
                            state_n = ST_PRESSED;
                            key_n   = cand;
                            valid_n = 1'b1;
                            rel_n   = '0;
`ifdef KEYPAD_REPEAT_EN
                            rpt_n   = '0;
`endif
                        end
                    end else if (res_kind == RES_SINGLE) begin
                        cand_n  = res_code;
                        match_n = DW'(1);
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_PRESSED: begin
                    if (res_kind == RES_NONE) begin
                        rel_n = rel_cnt + DW'(1);
                        if (rel_n == DW'(DEBOUNCE_SCANS)) begin
                            state_n = ST_IDLE;
                        end
                    end else begin
                        // A different key stays silent until a full release.
                        rel_n = '0;
                    end
`ifdef KEYPAD_REPEAT_EN
                    if (res_kind == RES_SINGLE && res_code == key_q) begin
                        rpt_n = rpt_cnt + RW'(1);
                        if (rpt_n == RW'(REPEAT_SCANS)) begin
                            rpt_n   = '0;
                            valid_n = 1'b1;
                        end
                    end else begin
                        rpt_n = '0;
                    end
`endif
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    assign key_bus.KEY       = key_q;
    assign key_bus.KEY_VALID = valid_q;
    assign key_bus.KEY_HELD  = (state == ST_PRESSED);

endmodule

// File: tb/tb_keypad_scan_decode.sv
// Directed bench for keypad_scan_decode: a behavioural keypad drives ROW from COL and a key mask.
module tb_keypad_scan_decode;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 2;
    localparam int REP      = 3;
    localparam int SCAN_CYC = 4 * SCAN_DIV;
`ifdef KEYPAD_REPEAT_EN
    localparam int HOLD_A_STROBES = 3;
`else
    localparam int HOLD_A_STROBES = 1;
`endif

    typedef struct {
        string      name;
        logic [15:0] mask;
        int         scans;
        int         exp_strobes;
        logic [3:0] exp_key;
        logic       exp_held;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] mask;

    int          checks = 0;
    int          errors = 0;
    int          strobes;
    logic        prev_valid;
    logic [3:0]  exp_strobe_key;
    bit          mon_en;
    vec_t        vq[$];

    keypad_scan_decode_if kif();

    keypad_scan_decode #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEB),
        .REPEAT_SCANS   (REP)
    ) dut (
        .CLK100MHZ  (clk),
        .CPU_RESETN (rst_n),
        .ROW        (row),
        .COL        (col),
        .key_bus    (kif)
    );

    always #5 clk = ~clk;

    // Mask bit c*4+r is the key at column c, row r.
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (col[c] == 1'b0 && mask[c*4 + r]) row[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (mon_en) begin
            check("col_one_low", $countones(~col), 1);
            if (kif.KEY_VALID === 1'b1) begin
                strobes++;
                check("strobe_key", {28'd0, kif.KEY}, {28'd0, exp_strobe_key});
            end
            if (prev_valid) check("valid_single_cycle", {31'd0, kif.KEY_VALID}, 0);
        end
        prev_valid = (kif.KEY_VALID === 1'b1);
    endtask

    task automatic add(input string n, input logic [15:0] m, input int s,
                       input int es, input logic [3:0] k, input logic h);
        vec_t v;
        v.name = n; v.mask = m; v.scans = s;
        v.exp_strobes = es; v.exp_key = k; v.exp_held = h;
        vq.push_back(v);
    endtask

    initial begin
        logic [3:0] col_exp [5];
        int         col_at  [5];
        col_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        col_at  = '{1, 4, 8, 12, 16};

        rst_n = 1'b0; mask = '0; mon_en = 0; prev_valid = 1'b0;
        strobes = 0; exp_strobe_key = 4'h0;

        // key 5 = bit 5, 9 = bit 10, 1 = bit 0, 2 = bit 4, D = bit 15, A = bit 12
        add("idle",        16'h0000, 2,  0,              4'h0, 1'b0);
        add("hold5",       16'h0020, 4,  1,              4'h5, 1'b1);
        add("rel5_one",    16'h0000, 1,  0,              4'h5, 1'b1);
        add("rel5_two",    16'h0000, 1,  0,              4'h5, 1'b0);
        add("tap9",        16'h0400, 1,  0,              4'h5, 1'b0);
        add("after9",      16'h0000, 2,  0,              4'h5, 1'b0);
        add("multi12",     16'h0011, 4,  0,              4'h5, 1'b0);
        add("press5",      16'h0020, 3,  1,              4'h5, 1'b1);
        add("switchD",     16'h8000, 3,  0,              4'h5, 1'b1);
        add("relD",        16'h0000, 2,  0,              4'h5, 1'b0);
        add("pressD",      16'h8000, 2,  1,              4'hD, 1'b1);
        add("relD2",       16'h0000, 2,  0,              4'hD, 1'b0);
        add("holdA",       16'h1000, 10, HOLD_A_STROBES, 4'hA, 1'b1);

        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_col",   {28'd0, col},          32'hE);
            check("rst_key",   {28'd0, kif.KEY},      0);
            check("rst_valid", {31'd0, kif.KEY_VALID}, 0);
            check("rst_held",  {31'd0, kif.KEY_HELD},  0);
        end
        mon_en = 1;
        rst_n  = 1'b1;

        for (int t = 1; t <= 17; t++) begin
            tick();
            for (int j = 0; j < 5; j++)
                if (col_at[j] == t) check($sformatf("col_step_%0d", t), {28'd0, col}, {28'd0, col_exp[j]});
        end
        check("no_strobe_after_reset", strobes, 0);

        for (int i = 0; i < vq.size(); i++) begin
            mask           = vq[i].mask;
            exp_strobe_key = vq[i].exp_key;
            strobes        = 0;
            repeat (vq[i].scans * SCAN_CYC) tick();
            check({vq[i].name, "_strobes"}, strobes, vq[i].exp_strobes);
            check({vq[i].name, "_key"},  {28'd0, kif.KEY},      {28'd0, vq[i].exp_key});
            check({vq[i].name, "_held"}, {31'd0, kif.KEY_HELD}, {31'd0, vq[i].exp_held});
        end

        // Reset while PRESSED with key A still down.
        strobes = 0;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        check("midrst_held",  {31'd0, kif.KEY_HELD},  0);
        check("midrst_key",   {28'd0, kif.KEY},       0);
        check("midrst_col",   {28'd0, col},           32'hE);
        check("midrst_valid", {31'd0, kif.KEY_VALID}, 0);
        tick();
        rst_n = 1'b1;
        repeat (17) tick();
        check("midrst_no_strobe", strobes, 0);
        check("midrst_confirm_held", {31'd0, kif.KEY_HELD}, 0);
        repeat (SCAN_CYC) tick();
        check("midrst_reaccept", strobes, 1);
        check("midrst_reaccept_key", {28'd0, kif.KEY}, 32'hA);
        check("midrst_reaccept_held", {31'd0, kif.KEY_HELD}, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scan_decode.md
# keypad_scan_decode

Input-side companion to the multiplexed 7-segment display path on the Nexys4DDR. It scans a 4x4 hex keypad on a Pmod port by driving one column low at a time and reading the rows. It debounces each press and emits a 4-bit hex key code with a one-cycle valid strobe. It sits in the top level beside the button counter, so a typed hex digit can feed a counter or be shown on the 7-seg digits.

## Interface
- SCAN_DIV, 100000: clock cycles each column is driven (1 ms at 100 MHz); minimum 4.
- DEBOUNCE_SCANS, 4: consecutive identical full-scan results needed to accept a press or a release; minimum 1.
- REPEAT_SCANS, 250: full scans between auto-repeat strobes; used only when the repeat feature is compiled in.
- CLK100MHZ  in  1  sole clock; all logic on its rising edge.
- CPU_RESETN  in  1  reset, synchronous, active-low.
- ROW  in  4  keypad rows; active-low, externally pulled up, asynchronous to the clock.
- COL  out  4  keypad column drive; active-low, exactly one bit low at a time.
- KEY  out  4  hex code of the accepted key; holds its value after release.
- KEY_VALID  out  1  one-cycle strobe when a new key is accepted.
- KEY_HELD  out  1  high from acceptance until the release is debounced.

## Operation
- ROW passes through a 2-flop synchronizer before any use.
- **Column scan**
  - A dwell counter runs 0..SCAN_DIV-1. On wrap, the column index (0..3) increments modulo 4.
  - COL = ~(1 << index).
  - Rows for the current column are captured on the last dwell cycle (count = SCAN_DIV-1).
- **Scan result**
  - After column 3 is captured, the 16 captured bits are classified as NONE, SINGLE(code) or MULTI (two or more keys down).
  - This evaluation is the "scan end" strobe.
- **Key map** [column][row]:
  - col0 = 1,4,7,0
  - col1 = 2,5,8,F
  - col2 = 3,6,9,E
  - col3 = A,B,C,D
- **Debounce FSM**, evaluated only at scan end:
  - IDLE
    - SINGLE(c): store c as candidate, match count = 1, go to CONFIRM. If DEBOUNCE_SCANS = 1, accept immediately instead.
    - NONE or MULTI: stay in IDLE.
  - CONFIRM
    - SINGLE matching the candidate: increment the count. When it reaches DEBOUNCE_SCANS, load KEY, pulse KEY_VALID and go to PRESSED.
    - SINGLE with a different code: restart with the new candidate at count 1.
    - NONE or MULTI: go to IDLE.
  - PRESSED
    - NONE: increment the release count. When it reaches DEBOUNCE_SCANS, go to IDLE.
    - Anything else: clear the release count. A different key gives no strobe until after a full release.
- KEY_HELD = 1 in PRESSED; KEY_VALID is never high for two consecutive cycles.
- **Reset** (CPU_RESETN = 0 at an edge, including mid-scan or mid-press):
  - COL = 4'b1110, KEY = 0, KEY_VALID = 0, KEY_HELD = 0, FSM = IDLE, all counters and the synchronizer cleared.
  - No strobe is generated on reset entry or exit.

## Timing
- Scan period is 4·SCAN_DIV cycles. Scan end falls 1 cycle after the column-3 capture edge.
- KEY_VALID rises on the cycle after the scan end that completes the DEBOUNCE_SCANS-th matching scan. KEY is valid on that same cycle.
- Input-to-capture delay is 2 cycles (synchronizer). A row change in the last 2 dwell cycles misses that scan.
- Worst-case press latency is (DEBOUNCE_SCANS+1)·4·SCAN_DIV + 3 cycles.
- COL changes only on dwell wrap, 1 cycle after capture.

## Configuration
- KEYPAD_REPEAT_EN defined:
  - While in PRESSED and the scan result is SINGLE(KEY), a repeat counter counts scan ends.
  - Every REPEAT_SCANS of them, KEY_VALID pulses again with KEY unchanged.
  - The counter clears on entry to PRESSED and on any non-matching scan.
- Not defined: exactly one KEY_VALID per press; the repeat counter and the REPEAT_SCANS logic are absent.

## Structure
- **keypad_pkg**
  - KEY_MAP constant (4x4 of 4-bit codes).
  - FSM state enum (IDLE, CONFIRM, PRESSED).
  - Scan-result enum (NONE, SINGLE, MULTI).
- **keypad_col_scan** sub-module
  - Contains the synchronizer, dwell counter, column drive, capture and classification.
  - Outputs the scan-end strobe, result kind and code.
- The top module holds the debounce FSM and the optional repeat logic.

## Test plan
All scenarios use SCAN_DIV=4, DEBOUNCE_SCANS=2, REPEAT_SCANS=3.
1. Reset held 3 cycles, then released, ROW=4'hF.
   - During reset: COL=1110, KEY=0, KEY_VALID=0, KEY_HELD=0.
   - After release: COL steps 1110→1101→1011→0111→1110 every 4 cycles; no strobe.
2. Hold key 5 (ROW[1] low whenever COL[1] low) for 4 scans.
   - Exactly one KEY_VALID, with KEY=4'h5, after the 2nd full scan; KEY_HELD=1.
   - KEY_HELD=0 two scans after release; KEY stays 5.
3. Press key 9 for 1 scan only, or press 1 and 2 together for 4 scans: no KEY_VALID and KEY_HELD stays 0.
4. Press key 5 and hold, then switch to D without releasing, then release fully and press D.
   - No strobe at the switch.
   - One strobe with KEY=4'hD after the debounced release and 2 scans of D.
5. Assert reset while in PRESSED: the next cycle shows KEY_HELD=0, KEY=0, COL=1110, and no KEY_VALID.
6. With KEYPAD_REPEAT_EN, hold key A for 10 scans: KEY_VALID at acceptance, then every 3 scan ends, always with KEY=4'hA. Without the macro: exactly one strobe.
